// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencing controller:
// FSM states, opcodes, ALU operation codes and datapath select values.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_JALR1, S_JALR2, S_BRANCH, S_LUI,
        S_ERROR
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_DECODE = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_ITYPE, OP_JALR: imm_src_of = IMM_I;
            OP_STORE:                   imm_src_of = IMM_S;
            OP_BRANCH:                  imm_src_of = IMM_B;
            OP_JAL:                     imm_src_of = IMM_J;
            OP_LUI:                     imm_src_of = IMM_U;
            default:                    imm_src_of = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus instruction fields to the ALU operation code.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       func75,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_DECODE: begin
                case (funct3)
                    // Only R-type uses bit 30 to select sub; for addi it is immediate data.
                    3'b000:  alu_control = (func75 && op5) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_control = ALU_AND;
                    3'b110:  alu_control = ALU_OR;
                    3'b100:  alu_control = ALU_XOR;
                    3'b010:  alu_control = ALU_SLT;
                    3'b001:  alu_control = ALU_SLL;
                    3'b101:  alu_control = ALU_SRL;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencing FSM for the multi-cycle RV32I core; PCWrite is the
// only output that also depends on the current Zero flag.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       func75,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       busy,
    output logic       halted
);

    state_t     state_reg, state_next;
    logic       pc_update, branch, taken;
    logic [1:0] alu_op;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (trigger) state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR1;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_LUI:            state_next = S_LUI;
                    default:           state_next = S_ERROR;
                endcase
            end
            S_MEMADR:   state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_JALR1:    state_next = S_JALR2;
            S_JALR2:    state_next = S_ALUWB;
            S_BRANCH:   state_next = S_FETCH;
            S_LUI:      state_next = S_ALUWB;
            S_ERROR:    state_next = S_ERROR;
            default:    state_next = S_ERROR;
        endcase
    end

    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        alu_op    = ALUOP_ADD;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        busy      = (state_reg != S_IDLE) && (state_reg != S_ERROR);
        halted    = (state_reg == S_ERROR);
        case (state_reg)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                pc_update = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR, S_JALR1: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_DECODE;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_DECODE;
            end
            S_ALUWB: RegWrite = 1'b1;
            // The ALU computes OldPC+4 for the link while ALUOut already holds the target.
            S_JAL, S_JALR2: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = !Zero;
            default: taken = 1'b0;
        endcase
    end

    assign PCWrite = pc_update | (branch & taken);
    assign ImmSrc  = imm_src_of(opcode);

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .func75      (func75),
        .op5         (opcode[5]),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks instructions state by state and
// compares the packed control vector against hand-derived values.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset, trigger, func75, Zero;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, busy, halted;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc, ALUControl;

    int passed = 0;
    int total  = 0;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .trigger(trigger), .opcode(opcode),
        .funct3(funct3), .func75(func75), .Zero(Zero), .PCWrite(PCWrite),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    // {PCWrite,AdrSrc,IRWrite,MemWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,busy,halted}
    function automatic logic [15:0] v(input logic pcw, adr, irw, mw, rw,
                                      input logic [1:0] rs, sa, sb,
                                      input logic [2:0] ac, input logic bz, hl);
        return {pcw, adr, irw, mw, rw, rs, sa, sb, ac, bz, hl};
    endfunction

    localparam logic [15:0] V_IDLE     = v(0,0,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 0,0);
    localparam logic [15:0] V_FETCH    = v(1,0,1,0,0, 2'd2,2'd0,2'd2, 3'd0, 1,0);
    localparam logic [15:0] V_DECODE   = v(0,0,0,0,0, 2'd0,2'd1,2'd1, 3'd0, 1,0);
    localparam logic [15:0] V_EXECR_AD = v(0,0,0,0,0, 2'd0,2'd2,2'd0, 3'd0, 1,0);
    localparam logic [15:0] V_EXECR_SB = v(0,0,0,0,0, 2'd0,2'd2,2'd0, 3'd1, 1,0);
    localparam logic [15:0] V_EXECI_AD = v(0,0,0,0,0, 2'd0,2'd2,2'd1, 3'd0, 1,0);
    localparam logic [15:0] V_ALUWB    = v(0,0,0,0,1, 2'd0,2'd0,2'd0, 3'd0, 1,0);
    localparam logic [15:0] V_MEMADR   = v(0,0,0,0,0, 2'd0,2'd2,2'd1, 3'd0, 1,0);
    localparam logic [15:0] V_MEMREAD  = v(0,1,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 1,0);
    localparam logic [15:0] V_MEMWB    = v(0,0,0,0,1, 2'd1,2'd0,2'd0, 3'd0, 1,0);
    localparam logic [15:0] V_MEMWRITE = v(0,1,0,1,0, 2'd0,2'd0,2'd0, 3'd0, 1,0);
    localparam logic [15:0] V_BR_TAKEN = v(1,0,0,0,0, 2'd0,2'd2,2'd0, 3'd1, 1,0);
    localparam logic [15:0] V_BR_NOT   = v(0,0,0,0,0, 2'd0,2'd2,2'd0, 3'd1, 1,0);
    localparam logic [15:0] V_JALR1    = v(0,0,0,0,0, 2'd0,2'd2,2'd1, 3'd0, 1,0);
    localparam logic [15:0] V_JALR2    = v(1,0,0,0,0, 2'd0,2'd1,2'd2, 3'd0, 1,0);
    localparam logic [15:0] V_ERROR    = v(0,0,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 0,1);

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [31:0] instr);
        opcode = instr[6:0];
        funct3 = instr[14:12];
        func75 = instr[30];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_st(input string tag, input logic [15:0] exp);
        chk(tag, {16'h0, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUControl, busy, halted}, {16'h0, exp});
    endtask

    // Called while in FETCH; counts cycles until the next FETCH, bounded.
    task automatic chk_cpi(input string tag, input int exp);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!IRWrite && n < 20);
        chk(tag, n, exp);
    endtask

    initial begin
        reset = 1'b1; trigger = 1'b0; Zero = 1'b0;
        set_instr(32'h00208033);
        step(); step();
        chk_st("reset_idle", V_IDLE);
        chk("idle_imm", {29'h0, ImmSrc}, 32'd0);
        reset = 1'b0;
        step();
        chk_st("idle_hold", V_IDLE);

        // add: FETCH, DECODE, EXECR, ALUWB
        trigger = 1'b1;
        step(); trigger = 1'b0;
        chk_st("add_fetch", V_FETCH);
        step(); chk_st("add_decode", V_DECODE);
        step(); chk_st("add_execr", V_EXECR_AD);
        step(); chk_st("add_aluwb", V_ALUWB);
        set_instr(32'h40208033);
        trigger = 1'b1;  // must be ignored outside IDLE
        step(); chk_st("sub_fetch", V_FETCH);
        trigger = 1'b0;
        step(); chk_st("sub_decode", V_DECODE);
        step(); chk_st("sub_execr", V_EXECR_SB);
        step(); chk_st("sub_aluwb", V_ALUWB);

        // lw then sw
        set_instr(32'h0000A103);
        step(); chk_st("lw_fetch", V_FETCH);
        step(); chk_st("lw_decode", V_DECODE);
        chk("lw_imm", {29'h0, ImmSrc}, 32'd0);
        step(); chk_st("lw_memadr", V_MEMADR);
        step(); chk_st("lw_memread", V_MEMREAD);
        step(); chk_st("lw_memwb", V_MEMWB);
        set_instr(32'h0020A023);
        step(); chk_st("sw_fetch", V_FETCH);
        step(); chk_st("sw_decode", V_DECODE);
        chk("sw_imm", {29'h0, ImmSrc}, 32'd1);
        step(); chk_st("sw_memadr", V_MEMADR);
        step(); chk_st("sw_memwrite", V_MEMWRITE);

        // beq Zero=1, beq Zero=0, bne Zero=0
        set_instr(32'h00208063); Zero = 1'b1;
        step(); chk_st("beq1_fetch", V_FETCH);
        chk("beq_imm", {29'h0, ImmSrc}, 32'd2);
        step(); chk_st("beq1_decode", V_DECODE);
        step(); chk_st("beq1_branch", V_BR_TAKEN);
        Zero = 1'b0;
        step(); chk_st("beq0_fetch", V_FETCH);
        step(); chk_st("beq0_decode", V_DECODE);
        step(); chk_st("beq0_branch", V_BR_NOT);
        set_instr(32'h00209063);
        step(); chk_st("bne0_fetch", V_FETCH);
        step(); chk_st("bne0_decode", V_DECODE);
        step(); chk_st("bne0_branch", V_BR_TAKEN);

        // jalr: FETCH, DECODE, JALR1, JALR2, ALUWB
        set_instr(32'h000080E7);
        step(); chk_st("jalr_fetch", V_FETCH);
        step(); chk_st("jalr_decode", V_DECODE);
        step(); chk_st("jalr_1", V_JALR1);
        step(); chk_st("jalr_2", V_JALR2);
        step(); chk_st("jalr_aluwb", V_ALUWB);

        // addi with bit 30 set must still add
        set_instr(32'hC0000093);
        step(); chk_st("addi_fetch", V_FETCH);
        step(); chk_st("addi_decode", V_DECODE);
        step(); chk_st("addi_execi", V_EXECI_AD);
        step(); chk_st("addi_aluwb", V_ALUWB);

        // jal and lui cycle counts
        set_instr(32'h0000006F);
        step(); chk_st("jal_fetch", V_FETCH);
        set_instr(32'h0000006F);
        chk_cpi("jal_cpi", 4);
        set_instr(32'h000000B7);
        chk_cpi("lui_cpi", 4);

        // illegal opcode -> sticky ERROR, trigger ignored
        set_instr(32'h0000007F);
        step(); chk_st("bad_decode", V_DECODE);
        trigger = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(); chk_st("error_hold", V_ERROR);
        end

        // reset and trigger together: reset wins
        reset = 1'b1;
        step(); chk_st("rst_trig_idle", V_IDLE);
        reset = 1'b0; trigger = 1'b0;
        step(); chk_st("after_rst_idle", V_IDLE);

        // reset during MEMREAD of lw: no MEMWB write follows
        set_instr(32'h0000A103);
        trigger = 1'b1;
        step(); trigger = 1'b0;
        chk_st("lw2_fetch", V_FETCH);
        step(); chk_st("lw2_decode", V_DECODE);
        step(); chk_st("lw2_memadr", V_MEMADR);
        step(); chk_st("lw2_memread", V_MEMREAD);
        reset = 1'b1;
        step(); chk_st("lw2_rst_idle", V_IDLE);
        reset = 1'b0;
        step(); chk_st("lw2_idle_hold", V_IDLE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
